// File: rtl/vga_display_controller_pkg.sv
// Shared VGA 640x480@60 timing constants and sync polarity.
// The render pipeline imports this package too.
package vga_display_controller_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_display_controller_scan_counter.sv
// Modulo-N scan counter with enable. Exposes its next-state value so decodes
// can be registered in step with the count.
module scan_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_display_controller.sv
// VGA timing generator: 50 MHz clk divided by 2 into a pixel tick, scan
// counters, and registered sync/blank decodes aligned with h_pos/v_pos.
module vga_display_controller
  import vga_display_controller_pkg::*;
#(
  parameter int HCOUNT_WIDTH = 10,
  parameter int VCOUNT_WIDTH = 10,
  parameter int H_VISIBLE    = vga_display_controller_pkg::VGA_H_VISIBLE,
  parameter int H_FRONT      = vga_display_controller_pkg::VGA_H_FRONT,
  parameter int H_SYNC       = vga_display_controller_pkg::VGA_H_SYNC,
  parameter int H_BACK       = vga_display_controller_pkg::VGA_H_BACK,
  parameter int V_VISIBLE    = vga_display_controller_pkg::VGA_V_VISIBLE,
  parameter int V_FRONT      = vga_display_controller_pkg::VGA_V_FRONT,
  parameter int V_SYNC       = vga_display_controller_pkg::VGA_V_SYNC,
  parameter int V_BACK       = vga_display_controller_pkg::VGA_V_BACK
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [HCOUNT_WIDTH-1:0] h_pos,
  output logic [VCOUNT_WIDTH-1:0] v_pos,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    hblank,
  output logic                    vblank
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HCOUNT_WIDTH-1:0] H_BLANK_START = HCOUNT_WIDTH'(H_VISIBLE);
  localparam logic [HCOUNT_WIDTH-1:0] H_SYNC_START  = HCOUNT_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [HCOUNT_WIDTH-1:0] H_SYNC_END    = HCOUNT_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_BLANK_START = VCOUNT_WIDTH'(V_VISIBLE);
  localparam logic [VCOUNT_WIDTH-1:0] V_SYNC_START  = VCOUNT_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [VCOUNT_WIDTH-1:0] V_SYNC_END    = VCOUNT_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic                    toggle_q, toggle_d;
  logic                    pix_tick;
  logic                    h_wrap;
  logic                    v_en;
  logic                    v_wrap_unused;
  logic [HCOUNT_WIDTH-1:0] h_next;
  logic [VCOUNT_WIDTH-1:0] v_next;
  logic                    hsync_q, hsync_d;
  logic                    vsync_q, vsync_d;
  logic                    hblank_q, hblank_d;
  logic                    vblank_q, vblank_d;

  // Counters advance on edges where the toggle was already 1.
  assign pix_tick = toggle_q;
  assign v_en     = pix_tick & h_wrap;

  scan_counter #(
    .WIDTH   (HCOUNT_WIDTH),
    .MODULUS (H_TOTAL)
  ) u_h_counter (
    .clk        (clk),
    .rst        (reset),
    .en         (pix_tick),
    .count      (h_pos),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  scan_counter #(
    .WIDTH   (VCOUNT_WIDTH),
    .MODULUS (V_TOTAL)
  ) u_v_counter (
    .clk        (clk),
    .rst        (reset),
    .en         (v_en),
    .count      (v_pos),
    .count_next (v_next),
    .wrap       (v_wrap_unused)
  );

  // Decode the next counter values so the registered flags line up with h_pos/v_pos.
  always_comb begin
    toggle_d = ~toggle_q;
    hsync_d  = ((h_next >= H_SYNC_START) && (h_next <= H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d  = ((v_next >= V_SYNC_START) && (v_next <= V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    hblank_d = (h_next >= H_BLANK_START);
    vblank_d = (v_next >= V_BLANK_START);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
      hsync_q  <= ~SYNC_ACTIVE;
      vsync_q  <= ~SYNC_ACTIVE;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
    end
  end

  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign hblank = hblank_q;
  assign vblank = vblank_q;

endmodule

// File: tb/tb_vga_display_controller.sv
// Directed bench: full-size timing instance plus a short-frame instance
// (10 lines) so vertical decode and frame wrap are reachable quickly.
`timescale 1ns/1ps
module tb_vga_display_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] h_pos, v_pos, sh_pos, sv_pos;
  logic       hsync, vsync, hblank, vblank;
  logic       s_hsync, s_vsync, s_hblank, s_vblank;

  int checks = 0;
  int errors = 0;
  int e = 0;  // clk edges since reset release

  always #10 clk = ~clk;

  vga_display_controller dut (
    .clk(clk), .reset(reset), .h_pos(h_pos), .v_pos(v_pos),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank)
  );

  // Short frame: lines 0-3 visible, 4-5 front, 6-7 sync, 8-9 back.
  vga_display_controller #(
    .HCOUNT_WIDTH(10), .VCOUNT_WIDTH(10),
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_small (
    .clk(clk), .reset(reset), .h_pos(sh_pos), .v_pos(sv_pos),
    .hsync(s_hsync), .vsync(s_vsync), .hblank(s_hblank), .vblank(s_vblank)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  // Advance to the first edge showing absolute pixel index p since release.
  task automatic goto_pix(input int p);
    clk_n(2 * p - e);
  endtask

  initial begin
    int n;
    #25;
    check("rst_h_pos", 32'(h_pos), 0);
    check("rst_v_pos", 32'(v_pos), 0);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_hblank", 32'(hblank), 0);
    check("rst_vblank", 32'(vblank), 0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    e = 0;
    clk_n(1); check("rel_e1_h", 32'(h_pos), 0);
    clk_n(1); check("rel_e2_h", 32'(h_pos), 1);
    clk_n(1); check("rel_e3_h", 32'(h_pos), 1);
    clk_n(1); check("rel_e4_h", 32'(h_pos), 2);

    goto_pix(639);
    check("h639_h", 32'(h_pos), 639);
    check("h639_hblank", 32'(hblank), 0);
    goto_pix(640);
    check("h640_hblank", 32'(hblank), 1);
    check("h640_hsync", 32'(hsync), 1);
    goto_pix(655);
    check("h655_hsync", 32'(hsync), 1);
    goto_pix(656);
    check("h656_h", 32'(h_pos), 656);
    check("h656_hsync", 32'(hsync), 0);
    n = 0;
    while (hsync === 1'b0 && n < 400) begin
      clk_n(1);
      n++;
    end
    check("hsync_low_cycles", 32'(n), 192);
    check("h752_h", 32'(h_pos), 752);
    check("h752_hsync", 32'(hsync), 1);
    goto_pix(799);
    check("h799_h", 32'(h_pos), 799);
    check("h799_v", 32'(v_pos), 0);
    check("h799_hblank", 32'(hblank), 1);
    goto_pix(800);
    check("wrap_h", 32'(h_pos), 0);
    check("wrap_v", 32'(v_pos), 1);
    check("wrap_hblank", 32'(hblank), 0);
    check("wrap_hsync", 32'(hsync), 1);
    goto_pix(1600);
    check("line2_v", 32'(v_pos), 2);

    goto_pix(3 * 800 + 799);
    check("s_l3_vblank", 32'(s_vblank), 0);
    check("s_l3_v", 32'(sv_pos), 3);
    goto_pix(4 * 800);
    check("s_l4_vblank", 32'(s_vblank), 1);
    check("d_l4_vblank", 32'(vblank), 0);
    check("d_l4_v", 32'(v_pos), 4);
    goto_pix(5 * 800 + 799);
    check("s_l5_vsync", 32'(s_vsync), 1);
    goto_pix(6 * 800);
    check("s_l6_vsync", 32'(s_vsync), 0);
    check("d_l6_vsync", 32'(vsync), 1);
    goto_pix(7 * 800 + 799);
    check("s_l7_vsync", 32'(s_vsync), 0);
    goto_pix(8 * 800);
    check("s_l8_vsync", 32'(s_vsync), 1);
    goto_pix(9 * 800 + 799);
    check("s_last_h", 32'(sh_pos), 799);
    check("s_last_v", 32'(sv_pos), 9);
    check("s_last_vblank", 32'(s_vblank), 1);
    goto_pix(10 * 800);
    check("s_fwrap_h", 32'(sh_pos), 0);
    check("s_fwrap_v", 32'(sv_pos), 0);
    check("s_fwrap_vblank", 32'(s_vblank), 0);
    check("s_fwrap_vsync", 32'(s_vsync), 1);
    check("d_l10_v", 32'(v_pos), 10);

    goto_pix(10 * 800 + 6 * 800 + 700);
    check("s_sync_hsync", 32'(s_hsync), 0);
    check("s_sync_vsync", 32'(s_vsync), 0);
    reset = 1'b1;
    #1;
    check("arst_hsync", 32'(s_hsync), 1);
    check("arst_vsync", 32'(s_vsync), 1);
    check("arst_h", 32'(sh_pos), 0);
    check("arst_v", 32'(sv_pos), 0);
    check("arst_hblank", 32'(s_hblank), 0);
    check("arst_vblank", 32'(s_vblank), 0);
    check("arst_d_v", 32'(v_pos), 0);
    #200;
    check("hold_h", 32'(h_pos), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    e = 0;
    clk_n(1); check("rel2_e1_h", 32'(h_pos), 0);
    clk_n(1); check("rel2_e2_h", 32'(h_pos), 1);
    check("rel2_e2_sh", 32'(sh_pos), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
